// File: rtl/snn_cfg_pkg.sv
// Opcodes, FSM states and default field layout
// of the spiking-network configuration bank.
package snn_cfg_pkg;

  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] OP_COMMIT    = 8'h02;
  localparam logic [7:0] OP_RD_SHADOW = 8'h03;
  localparam logic [7:0] OP_RD_ACTIVE = 8'h04;
  localparam logic [7:0] OP_CLEAR     = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPCODE,
    S_ADDR,
    S_WR,
    S_RD,
    S_HOLD
  } cfg_state_t;

  localparam int OFF_INPUT_SPIKES = 0;
  localparam int OFF_DECAY        = 2;
  localparam int OFF_REFRACTORY   = 3;
  localparam int OFF_THRESHOLD    = 4;
  localparam int OFF_DIV_VALUE    = 5;
  localparam int OFF_WEIGHTS      = 8;
  localparam int OFF_DELAYS       = 136;
  localparam int OFF_DEBUG        = 200;

  function automatic logic op_known(input logic [7:0] op);
    return (op >= OP_WRITE) && (op <= OP_CLEAR);
  endfunction

  function automatic logic op_has_addr(input logic [7:0] op);
    return (op == OP_WRITE) ||
           (op == OP_RD_SHADOW) ||
           (op == OP_RD_ACTIVE);
  endfunction

endpackage

// File: rtl/snn_cfg_regfile.sv
// Byte-wide register array with write port, read mux,
// whole-bank load and synchronous clear.
module snn_cfg_regfile #(
  parameter int NUM_BYTES = 224,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [7:0]             wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [7:0]             rdata,
  input  logic                   load,
  input  logic [NUM_BYTES*8-1:0] load_data,
  input  logic                   clear,
  output logic [NUM_BYTES*8-1:0] bank
);

  logic [7:0] mem [NUM_BYTES];

  // Storage: clear beats bulk load beats byte write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BYTES; i++)
        mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_BYTES; i++)
        mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_BYTES; i++)
        mem[i] <= load_data[8*i +: 8];
    end else if (we) begin
      for (int i = 0; i < NUM_BYTES; i++)
        if (waddr == ADDR_W'(i))
          mem[i] <= wdata;
    end
  end

  // Flat bank view and addressed read byte.
  always_comb begin
    bank  = '0;
    rdata = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      bank[8*i +: 8] = mem[i];
      if (raddr == ADDR_W'(i))
        rdata = mem[i];
    end
  end

endmodule

// File: rtl/snn_config_bank.sv
// Framed byte-stream configuration store with
// shadow/active banks, readback and error flags.
module snn_config_bank #(
  parameter int NUM_BYTES     = 224,
  parameter int ADDR_W        = 8,
  parameter int DOUBLE_BUFFER = 1
) (
  input  logic                   system_clock,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   frame_end,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [NUM_BYTES*8-1:0] active_cfg,
  output logic                   commit_pulse,
  output logic                   busy,
  output logic                   err_overflow,
  output logic                   err_opcode,
  input  logic                   err_clear
);
  import snn_cfg_pkg::*;

  localparam int PW = (ADDR_W > 8 ? ADDR_W : 8) + 1;
  localparam logic [PW-1:0] LIMIT = PW'(NUM_BYTES);
  localparam logic [PW-1:0] ONE   = PW'(1);
  localparam bit DB = (DOUBLE_BUFFER != 0);

  cfg_state_t state_q, state_d;
  logic [PW-1:0] ptr_q;
  logic [7:0] op_q;
  logic wrote_q;

  logic byte_en, in_range, opc_hit, wr_hit;
  logic wr_en, wr_ovf, rd_issue, close_cmd;
  logic commit_do, clear_do, commit_wr;
  logic [7:0] eff_op, sh_rdata, ac_rdata, rd_byte;
  logic [NUM_BYTES*8-1:0] sh_bank;

  assign busy = (state_q != S_IDLE);

  // Byte strobes and frame-close actions.
  always_comb begin
    byte_en   = rx_valid && (!frame_start || frame_end);
    in_range  = ptr_q < LIMIT;
    opc_hit   = (state_q == S_OPCODE) && byte_en;
    wr_hit    = (state_q == S_WR) && byte_en;
    wr_en     = wr_hit && in_range;
    wr_ovf    = wr_hit && !in_range;
    rd_issue  = (state_q == S_RD) && !tx_valid &&
                !frame_start && !frame_end;
    eff_op    = opc_hit ? rx_data : op_q;
    close_cmd = frame_end &&
                ((state_q == S_HOLD) || opc_hit);
    commit_do = DB && close_cmd &&
                (eff_op == OP_COMMIT);
    clear_do  = DB && close_cmd &&
                (eff_op == OP_CLEAR);
    commit_wr = !DB && frame_end &&
                (state_q == S_WR) && (wrote_q || wr_en);
    rd_byte   = (DB && op_q == OP_RD_SHADOW) ?
                sh_rdata : ac_rdata;
  end

  // Next state: close first, then a new frame opens.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OPCODE:
        if (byte_en)
          state_d = op_has_addr(rx_data) ?
                    S_ADDR : S_HOLD;
      S_ADDR:
        if (byte_en)
          state_d = (op_q == OP_WRITE) ? S_WR : S_RD;
      default: state_d = state_q;
    endcase
    if (frame_end)   state_d = S_IDLE;
    if (frame_start) state_d = S_OPCODE;
  end

  // FSM state register.
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Pointer, latched opcode and readback byte.
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      op_q     <= '0;
      wrote_q  <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      if (frame_start) begin
        ptr_q   <= '0;
        op_q    <= '0;
        wrote_q <= 1'b0;
      end else begin
        if (opc_hit) op_q <= rx_data;
        if (state_q == S_ADDR && byte_en)
          ptr_q <= PW'(rx_data);
        if (wr_en) begin
          ptr_q   <= ptr_q + ONE;
          wrote_q <= 1'b1;
        end
        if (state_q == S_RD && tx_valid && tx_ready &&
            in_range && !frame_end)
          ptr_q <= ptr_q + ONE;
      end
      if (frame_start || frame_end) begin
        tx_valid <= 1'b0;
      end else if (rd_issue) begin
        tx_valid <= 1'b1;
        tx_data  <= in_range ? rd_byte : 8'h00;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

  // Sticky errors (set beats clear) and commit strobe.
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      err_overflow <= 1'b0;
      err_opcode   <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= commit_do || commit_wr;
      if (wr_ovf || (rd_issue && !in_range))
        err_overflow <= 1'b1;
      else if (err_clear)
        err_overflow <= 1'b0;
      if (opc_hit && !op_known(rx_data))
        err_opcode <= 1'b1;
      else if (err_clear)
        err_opcode <= 1'b0;
    end
  end

  generate
    if (DOUBLE_BUFFER != 0) begin : g_shadow
      snn_cfg_regfile #(
        .NUM_BYTES(NUM_BYTES),
        .ADDR_W   (ADDR_W)
      ) u_shadow (
        .clk      (system_clock),
        .rst_n    (reset),
        .we       (wr_en),
        .waddr    (ptr_q[ADDR_W-1:0]),
        .wdata    (rx_data),
        .raddr    (ptr_q[ADDR_W-1:0]),
        .rdata    (sh_rdata),
        .load     (1'b0),
        .load_data('0),
        .clear    (clear_do),
        .bank     (sh_bank)
      );
    end else begin : g_direct
      assign sh_rdata = '0;
      assign sh_bank  = '0;
    end
  endgenerate

  snn_cfg_regfile #(
    .NUM_BYTES(NUM_BYTES),
    .ADDR_W   (ADDR_W)
  ) u_active (
    .clk      (system_clock),
    .rst_n    (reset),
    .we       (wr_en && !DB),
    .waddr    (ptr_q[ADDR_W-1:0]),
    .wdata    (rx_data),
    .raddr    (ptr_q[ADDR_W-1:0]),
    .rdata    (ac_rdata),
    .load     (commit_do),
    .load_data(sh_bank),
    .clear    (1'b0),
    .bank     (active_cfg)
  );

endmodule

// File: tb/tb_snn_config_bank.sv
// Bench: double-buffered and direct-write banks driven
// with one stimulus stream against a byte-array model.
module tb_snn_config_bank;
  import snn_cfg_pkg::*;

  localparam int NBA = 224;
  localparam int NBB = 16;
  localparam int W   = NBA * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fs = 0, fe = 0, rv = 0, ec = 0, tr = 0;
  logic [7:0] rd = '0;

  logic tv_a, tv_b, cp_a, cp_b, bz_a, bz_b;
  logic eo_a, eo_b, ep_a, ep_b;
  logic [7:0] td_a, td_b;
  logic [NBA*8-1:0] act_a;
  logic [NBB*8-1:0] act_b;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_sh [2][NBA];
  logic [7:0] m_ac [2][NBA];
  bit m_cp [2];
  bit m_ovf [2];
  bit m_opc [2];
  bit m_wrote [2];
  int m_p [2];
  bit m_busy;
  logic [7:0] m_op;

  always #5 clk = ~clk;

  snn_config_bank #(
    .NUM_BYTES(NBA), .ADDR_W(8), .DOUBLE_BUFFER(1)
  ) dut_a (
    .system_clock(clk), .reset(rst_n),
    .frame_start(fs), .frame_end(fe),
    .rx_valid(rv), .rx_data(rd),
    .tx_valid(tv_a), .tx_data(td_a), .tx_ready(tr),
    .active_cfg(act_a), .commit_pulse(cp_a),
    .busy(bz_a), .err_overflow(eo_a),
    .err_opcode(ep_a), .err_clear(ec)
  );

  snn_config_bank #(
    .NUM_BYTES(NBB), .ADDR_W(4), .DOUBLE_BUFFER(0)
  ) dut_b (
    .system_clock(clk), .reset(rst_n),
    .frame_start(fs), .frame_end(fe),
    .rx_valid(rv), .rx_data(rd),
    .tx_valid(tv_b), .tx_data(td_b), .tx_ready(tr),
    .active_cfg(act_b), .commit_pulse(cp_b),
    .busy(bz_b), .err_overflow(eo_b),
    .err_opcode(ep_b), .err_clear(ec)
  );

  function automatic int nb_of(input int i);
    return (i == 0) ? NBA : NBB;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               name, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NBA; k++) begin
        m_sh[i][k] = '0;
        m_ac[i][k] = '0;
      end
      m_cp[i] = 0; m_ovf[i] = 0; m_opc[i] = 0;
      m_wrote[i] = 0; m_p[i] = 0;
    end
    m_busy = 0;
    m_op = '0;
  endtask

  task automatic tick(input bit s, input bit e,
                      input bit v, input logic [7:0] d,
                      input bit c);
    fs = s; fe = e; rv = v; rd = d; ec = c;
    @(posedge clk); #1;
    fs = 0; fe = 0; rv = 0; rd = '0; ec = 0;
    m_cp[0] = 0; m_cp[1] = 0;
    if (c) begin
      m_ovf[0] = 0; m_ovf[1] = 0;
      m_opc[0] = 0; m_opc[1] = 0;
    end
  endtask

  task automatic m_open();
    m_busy = 1; m_op = '0;
    for (int i = 0; i < 2; i++) begin
      m_p[i] = 0; m_wrote[i] = 0;
    end
  endtask

  task automatic m_close();
    if (m_op == OP_COMMIT) begin
      for (int k = 0; k < NBA; k++)
        m_ac[0][k] = m_sh[0][k];
      m_cp[0] = 1;
    end
    if (m_op == OP_CLEAR)
      for (int k = 0; k < NBA; k++)
        m_sh[0][k] = '0;
    if (m_op == OP_WRITE && m_wrote[1])
      m_cp[1] = 1;
    m_busy = 0;
  endtask

  task automatic m_write(input logic [7:0] b);
    for (int i = 0; i < 2; i++) begin
      if (m_p[i] < nb_of(i)) begin
        if (i == 0) m_sh[0][m_p[0]] = b;
        else begin
          m_ac[1][m_p[1]] = b;
          m_wrote[1] = 1;
        end
        m_p[i]++;
      end else begin
        m_ovf[i] = 1;
      end
    end
  endtask

  task automatic open_frame();
    tick(1, 0, 0, 8'h00, 0);
    m_open();
  endtask

  task automatic close_frame();
    tick(0, 1, 0, 8'h00, 0);
    m_close();
  endtask

  task automatic op_byte(input logic [7:0] op);
    tick(0, 0, 1, op, 0);
    m_op = op;
    if (!(op >= 8'h01 && op <= 8'h05)) begin
      m_opc[0] = 1; m_opc[1] = 1;
    end
  endtask

  task automatic addr_byte(input logic [7:0] a);
    tick(0, 0, 1, a, 0);
    m_p[0] = int'(a); m_p[1] = int'(a);
  endtask

  task automatic data_byte(input logic [7:0] b,
                           input bit last);
    tick(0, last, 1, b, 0);
    m_write(b);
    if (last) m_close();
  endtask

  task automatic read_check(input logic [7:0] op,
                            input logic [7:0] a,
                            input int n,
                            input int delay);
    logic [7:0] exp [2];
    open_frame();
    op_byte(op);
    addr_byte(a);
    for (int j = 0; j < n; j++) begin
      tick(0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 2; i++) begin
        if (m_p[i] < nb_of(i))
          exp[i] = (op == OP_RD_SHADOW && i == 0) ?
                   m_sh[0][m_p[0]] : m_ac[i][m_p[i]];
        else begin
          exp[i] = 8'h00;
          m_ovf[i] = 1;
        end
      end
      for (int w = 0; w <= delay; w++) begin
        chk("tx_valid_a", tv_a, 1);
        chk("tx_data_a", td_a, exp[0]);
        chk("tx_valid_b", tv_b, 1);
        chk("tx_data_b", td_b, exp[1]);
        if (w < delay) tick(0, 0, 0, 8'h00, 0);
      end
      tr = 1;
      tick(0, 0, 0, 8'h00, 0);
      tr = 0;
      for (int i = 0; i < 2; i++)
        if (m_p[i] < nb_of(i)) m_p[i]++;
      chk("tx_gap_a", tv_a, 0);
    end
    close_frame();
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : cmp
    logic [W-1:0] act;
    int bad;
    for (int i = 0; i < 2; i++) begin
      act = (i == 0) ? act_a : W'(act_b);
      bad = -1;
      for (int k = 0; k < nb_of(i); k++)
        if (bad < 0 && act[8*k +: 8] !== m_ac[i][k])
          bad = k;
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL active_cfg[%0d] byte %0d: got %0h want %0h",
                 i, bad, act[8*bad +: 8], m_ac[i][bad]);
      end
      chk($sformatf("commit_pulse[%0d]", i),
          (i == 0) ? cp_a : cp_b, m_cp[i]);
      chk($sformatf("busy[%0d]", i),
          (i == 0) ? bz_a : bz_b, m_busy);
      chk($sformatf("err_overflow[%0d]", i),
          (i == 0) ? eo_a : eo_b, m_ovf[i]);
      chk($sformatf("err_opcode[%0d]", i),
          (i == 0) ? ep_a : ep_b, m_opc[i]);
    end
  end

  initial begin
    m_reset();
    tick(0, 0, 0, 8'h00, 0);
    tick(0, 0, 0, 8'h00, 0);
    rst_n = 1'b1;
    tick(0, 0, 0, 8'h00, 0);
    chk("rst_active", act_a[63:0], 64'h0);
    chk("rst_busy", bz_a, 0);
    chk("rst_tx_valid", tv_a, 0);
    chk("rst_tx_data", td_a, 0);
    chk("rst_commit", cp_a, 0);

    // WRITE at 0x05: AA, BB
    open_frame();
    op_byte(OP_WRITE);
    addr_byte(8'h05);
    data_byte(8'hAA, 0);
    data_byte(8'hBB, 0);
    close_frame();
    chk("wr_active_a_unchanged", act_a[55:40], 16'h0000);
    chk("wr_direct_b", act_b[55:40], 16'hBBAA);
    chk("wr_direct_commit_b", cp_b, 1);
    chk("wr_no_commit_a", cp_a, 0);

    // COMMIT
    open_frame();
    op_byte(OP_COMMIT);
    close_frame();
    chk("commit_active_a", act_a[55:40], 16'hBBAA);
    chk("commit_pulse_a", cp_a, 1);
    tick(0, 0, 0, 8'h00, 0);
    chk("commit_pulse_a_drop", cp_a, 0);

    // WRITE at last byte, three bytes, last with frame_end
    open_frame();
    op_byte(OP_WRITE);
    addr_byte(8'(NBA - 1));
    data_byte(8'h11, 0);
    data_byte(8'h22, 0);
    data_byte(8'h33, 1);
    chk("ovf_set_a", eo_a, 1);
    chk("ovf_set_b", eo_b, 1);
    read_check(OP_RD_SHADOW, 8'(NBA - 1), 2, 0);
    tick(0, 0, 0, 8'h00, 1);
    chk("ovf_clear_a", eo_a, 0);

    // READ_ACTIVE at 0x05 with slow consumer
    read_check(OP_RD_ACTIVE, 8'h05, 2, 3);

    // Unknown opcode; trailing byte ignored
    open_frame();
    op_byte(8'h7F);
    tick(0, 0, 1, 8'h44, 0);
    close_frame();
    chk("opc_set_a", ep_a, 1);
    chk("opc_set_b", ep_b, 1);
    tick(0, 0, 0, 8'h00, 1);

    // COMMIT aborted by a new frame_start
    open_frame();
    op_byte(OP_COMMIT);
    open_frame();
    close_frame();
    chk("abort_no_commit", act_a[8*(NBA-1) +: 8], 8'h00);

    // CLEAR_SHADOW, then COMMIT closed by start+end together
    open_frame();
    op_byte(OP_CLEAR);
    close_frame();
    open_frame();
    op_byte(OP_COMMIT);
    tick(1, 1, 0, 8'h00, 0);
    m_close();
    m_open();
    chk("clear_commit_a", act_a[55:40], 16'h0000);
    chk("restart_busy_a", bz_a, 1);
    close_frame();

    // Direct write lands immediately in bank B
    open_frame();
    op_byte(OP_WRITE);
    addr_byte(8'h00);
    data_byte(8'h11, 0);
    chk("direct_now_b", act_b[7:0], 8'h11);
    chk("direct_no_pulse_b", cp_b, 0);
    data_byte(8'h12, 1);
    chk("direct_pulse_b", cp_b, 1);

    // Reset in the middle of a frame
    open_frame();
    op_byte(OP_WRITE);
    addr_byte(8'h02);
    data_byte(8'h5A, 0);
    rst_n = 1'b0;
    m_reset();
    tick(0, 0, 0, 8'h00, 0);
    chk("midrst_active_b", act_b[63:0], 64'h0);
    chk("midrst_busy_a", bz_a, 0);
    rst_n = 1'b1;
    tick(0, 0, 0, 8'h00, 0);
    tick(0, 0, 0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
